// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file with busy-bit scoreboard.
package reg_file_pkg;
    localparam int XLEN_D   = 32;
    localparam int NREGS_D  = 32;
    localparam int ZERO_REG = 0;

    function automatic int aw_of(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, issue handshake,
// and reset > flush > issue-set > writeback-clear priority.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int NREGS = NREGS_D,
    localparam int AW   = aw_of(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    output logic             iss_ready,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    output logic [NREGS-1:0] busy
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wb_live_s;
    logic             iss_zero_s;

    assign wb_live_s  = wb_en && (wb_addr != AW'(ZERO_REG));
    assign iss_zero_s = (iss_rd == AW'(ZERO_REG));

    // A writeback to the same register releases it for a new owner this cycle.
    assign iss_ready = !reset && !flush &&
                       (iss_zero_s || !busy_q[iss_rd] || (wb_en && (wb_addr == iss_rd)));

    assign busy = busy_q;

    // Next busy state; the issue set follows the clear so a new owner wins.
    always_comb begin
        busy_d = busy_q;
        if (reset) begin
            busy_d = '0;
        end else if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_live_s) begin
                busy_d[wb_addr] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
            if (iss_valid && iss_ready && !iss_zero_s) begin
                busy_d[iss_rd] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // Busy bit register.
    always_ff @(posedge clk) begin
        busy_q <= busy_d;
    end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with optional writeback bypass and
// a per-register busy scoreboard for in-flight writes.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int NREGS  = NREGS_D,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = aw_of(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]    rbusy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic              iss_ready,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush
);
    logic [XLEN-1:0]  data_q [NREGS];
    logic [XLEN-1:0]  data_d [NREGS];
    logic [NREGS-1:0] busy_s;
    logic             wb_live_s;

    assign wb_live_s = wb_en && (wb_addr != AW'(ZERO_REG));

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .busy      (busy_s)
    );

    // Next array contents; flush does not affect data.
    always_comb begin
        data_d = data_q;
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                data_d[r] = '0;
            end
        end else if (wb_live_s) begin
            data_d[wb_addr] = wb_data;
        end else begin
            data_d = data_q;
        end
    end

    // Data array register.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // Read ports; outputs are forced quiet while reset is held.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int p = 0; p < NRP; p++) begin
            if (reset || (raddr[p*AW +: AW] == AW'(ZERO_REG))) begin
                rdata[p*XLEN +: XLEN] = '0;
                rbusy[p]              = 1'b0;
            end else if ((BYPASS != 0) && wb_live_s && (wb_addr == raddr[p*AW +: AW])) begin
                rdata[p*XLEN +: XLEN] = wb_data;
                rbusy[p]              = 1'b0;
            end else begin
                rdata[p*XLEN +: XLEN] = data_q[raddr[p*AW +: AW]];
                rbusy[p]              = busy_s[raddr[p*AW +: AW]];
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench: directed vector table plus randomized traffic, with a
// bypassing and a non-bypassing instance checked against a behavioural model.
module tb_reg_file_sb;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRP = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NRP*AW-1:0] raddr = '0;
    logic [NRP*XLEN-1:0] rdata_b, rdata_n;
    logic [NRP-1:0]    rbusy_b, rbusy_n;
    logic              iss_valid = 1'b0;
    logic [AW-1:0]     iss_rd = '0;
    logic              iss_ready_b, iss_ready_n;
    logic              wb_en = 1'b0;
    logic [AW-1:0]     wb_addr = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              flush = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_bsy [NREGS];

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .BYPASS(0)) u_dut_nb (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_n),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ir;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_d1;
        logic        e_b1;
        logic        e_rdy;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (reset || a == 5'd0) return 32'd0;
        if (byp && wb_en && wb_addr == a) return wb_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (reset || a == 5'd0) return 1'b0;
        if (byp && wb_en && wb_addr == a) return 1'b0;
        return m_bsy[a];
    endfunction

    function automatic logic exp_ready();
        if (reset || flush) return 1'b0;
        return (iss_rd == 5'd0) || !m_bsy[iss_rd] || (wb_en && wb_addr == iss_rd);
    endfunction

    task automatic check_model();
        logic [4:0] a;
        for (int p = 0; p < NRP; p++) begin
            a = raddr[p*AW +: AW];
            chk($sformatf("byp_rdata%0d", p), 64'(rdata_b[p*XLEN +: XLEN]), 64'(exp_data(a, 1'b1)));
            chk($sformatf("byp_rbusy%0d", p), 64'(rbusy_b[p]), 64'(exp_busy(a, 1'b1)));
            chk($sformatf("nob_rdata%0d", p), 64'(rdata_n[p*XLEN +: XLEN]), 64'(exp_data(a, 1'b0)));
            chk($sformatf("nob_rbusy%0d", p), 64'(rbusy_n[p]), 64'(exp_busy(a, 1'b0)));
        end
        chk("byp_iss_ready", 64'(iss_ready_b), 64'(exp_ready()));
        chk("nob_iss_ready", 64'(iss_ready_n), 64'(exp_ready()));
    endtask

    task automatic model_step();
        bit rdy;
        rdy = exp_ready();
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r] = 32'd0;
                m_bsy[r] = 1'b0;
            end
        end else begin
            if (wb_en && wb_addr != 5'd0) m_mem[wb_addr] = wb_data;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) m_bsy[r] = 1'b0;
            end else begin
                if (wb_en && wb_addr != 5'd0) m_bsy[wb_addr] = 1'b0;
                if (iss_valid && rdy && iss_rd != 5'd0) m_bsy[iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic do_cycle();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r] = 32'd0;
            m_bsy[r] = 1'b0;
        end
        //          rst   we    wa     wd             iv    ir     fl    ra0    ra1    e_d1           e_b1  e_rdy
        vecs[0]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  32'h0,        1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd5,  32'hDEADBEEF, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b0, 5'd5,  5'd0,  32'h0,        1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  32'h0,        1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  5'd7,  32'h0,        1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd0,  5'd7,  32'h0,        1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 5'd7,  32'hA5,       1'b0, 5'd7,  1'b0, 5'd7,  5'd7,  32'hA5,       1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  1'b0, 5'd0,  5'd7,  32'hA5,       1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 5'd9,  32'h55,       1'b1, 5'd9,  1'b0, 5'd0,  5'd9,  32'h55,       1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  1'b0, 5'd9,  5'd9,  32'h55,       1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd0,  5'd3,  32'h0,        1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd0,  5'd3,  32'h0,        1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 5'd11, 32'h77,       1'b1, 5'd4,  1'b1, 5'd3,  5'd4,  32'h0,        1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd4,  1'b0, 5'd11, 5'd4,  32'h0,        1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 5'd10, 32'hFFFFFFFF, 1'b1, 5'd10, 1'b0, 5'd3,  5'd10, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd10, 1'b0, 5'd9,  5'd10, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 5'd10, 32'h1,        1'b1, 5'd10, 1'b0, 5'd9,  5'd10, 32'h0,        1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd10, 1'b0, 5'd9,  5'd10, 32'h0,        1'b0, 1'b1};

        for (int i = 0; i < 19; i++) begin
            reset     = vecs[i].rst;
            wb_en     = vecs[i].we;
            wb_addr   = vecs[i].wa;
            wb_data   = vecs[i].wd;
            iss_valid = vecs[i].iv;
            iss_rd    = vecs[i].ir;
            flush     = vecs[i].fl;
            raddr     = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_rdata1", i), 64'(rdata_b[XLEN +: XLEN]), 64'(vecs[i].e_d1));
            chk($sformatf("vec%0d_rbusy1", i), 64'(rbusy_b[1]), 64'(vecs[i].e_b1));
            chk($sformatf("vec%0d_iss_ready", i), 64'(iss_ready_b), 64'(vecs[i].e_rdy));
            do_cycle();
        end

        // Randomized traffic with small address range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_addr   = 5'($urandom_range(0, 11));
            wb_data   = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = 5'($urandom_range(0, 11));
            raddr     = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
